// File: rtl/sys_time_gen.sv
// System-time generator: a free-running WIDTH-bit counter gated by a synchronised LOCKED flag,
// with absolute load, slewed signed correction and a boundary TICK strobe.
module sys_time_gen #(
    parameter int WIDTH     = 64,
    parameter int INC       = 1,
    parameter int ADJ_WIDTH = 16,
    parameter int TICK_LOG2 = 9
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 LOCKED,
    input  logic                 SET_VALID,
    input  logic [WIDTH-1:0]     SET_TIME,
    input  logic                 ADJ_VALID,
    input  logic [ADJ_WIDTH-1:0] ADJ_DELTA,
    output logic [WIDTH-1:0]     SYS_TIME,
    output logic                 RUNNING,
    output logic                 ADJ_BUSY,
    output logic                 ADJ_REJECT,
    output logic                 TICK
);

    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] SLEW = 2'd2;

    localparam int RW = ADJ_WIDTH + 1;
    localparam logic [WIDTH-1:0]     INC_W = WIDTH'(INC);
    localparam logic [WIDTH-1:0]     ONE_W = WIDTH'(1);
    localparam logic signed [RW-1:0] R_ONE = RW'(1);

    logic                 lock_meta_reg;
    logic                 lock_sync_reg;
    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [WIDTH-1:0]     time_reg;
    logic [WIDTH-1:0]     time_next;
    logic [WIDTH-1:0]     step;
    logic signed [RW-1:0] r_reg;
    logic signed [RW-1:0] r_next;
    logic                 reject_reg;
    logic                 reject_next;
    logic                 cross_reg;
    logic                 cross_next;
    logic                 tick_reg;

    always_comb begin
        step        = '0;
        r_next      = r_reg;
        reject_next = ADJ_VALID && (SET_VALID || (r_reg != '0));

        // SLEW is only ever entered with a non-zero residual, so its sign picks the direction.
        case (state_reg)
            RUN: begin
                step = INC_W;
            end
            SLEW: begin
                if (r_reg[RW-1]) begin
                    step   = INC_W - ONE_W;
                    r_next = r_reg + R_ONE;
                end else begin
                    step   = INC_W + ONE_W;
                    r_next = r_reg - R_ONE;
                end
            end
            default: begin
                step = '0;
            end
        endcase

        time_next = time_reg + step;

        if (SET_VALID) begin
            time_next = SET_TIME;
            r_next    = '0;
        end else if (ADJ_VALID && (r_reg == '0)) begin
            r_next = {ADJ_DELTA[ADJ_WIDTH-1], ADJ_DELTA};
        end

        cross_next = !SET_VALID &&
                     (time_next[WIDTH-1:TICK_LOG2] != time_reg[WIDTH-1:TICK_LOG2]);

        // The state tracks the synchroniser output one-for-one, so HALT <=> RUNNING low.
        if (!lock_meta_reg) begin
            state_next = HALT;
        end else if (r_next != '0) begin
            state_next = SLEW;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
            state_reg     <= HALT;
            time_reg      <= '0;
            r_reg         <= '0;
            reject_reg    <= 1'b0;
            cross_reg     <= 1'b0;
            tick_reg      <= 1'b0;
        end else begin
            lock_meta_reg <= LOCKED;
            lock_sync_reg <= lock_meta_reg;
            state_reg     <= state_next;
            time_reg      <= time_next;
            r_reg         <= r_next;
            reject_reg    <= reject_next;
            cross_reg     <= cross_next;
            tick_reg      <= cross_reg;
        end
    end

    assign SYS_TIME   = time_reg;
    assign RUNNING    = lock_sync_reg;
    assign ADJ_BUSY   = (r_reg != '0);
    assign ADJ_REJECT = reject_reg;
    assign TICK       = tick_reg;

endmodule
